// File: rtl/uart_rx_data_sampler.sv
// UART RX oversampling data sampler: synchronizes the RX line, counts oversampling
// edges within each bit and majority-votes three mid-bit samples into one bit.
module uart_rx_data_sampler #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      Sampler_CLK,
  input  logic                      Sampler_RST,
  input  logic                      Sampler_RX_IN,
  input  logic                      Sampler_EN,
  input  logic [PRESCALE_WIDTH-1:0] Sampler_Prescale,
  output logic                      Sampler_SampledData,
  output logic                      Sampler_Sample_Valid,
  output logic [PRESCALE_WIDTH-1:0] Sampler_Edge_Cnt,
  output logic                      Sampler_Bit_Done
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE   = PRESCALE_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] P_MIN = PRESCALE_WIDTH'(8);

  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      rx_s;
  logic [PRESCALE_WIDTH-1:0] p_lat;
  logic [PRESCALE_WIDTH-1:0] p_eff;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] mid;
  logic [PRESCALE_WIDTH-1:0] mid_m1;
  logic [PRESCALE_WIDTH-1:0] mid_p1;
  logic [PRESCALE_WIDTH-1:0] cnt_last;
  logic                      at_last;
  logic                      s0;
  logic                      s1;
  logic                      vote;
  logic                      sampled_data;
  logic                      sample_valid;

  // Line idles high, so the chain resets to 1 to avoid a false start bit.
  always_ff @(posedge Sampler_CLK or negedge Sampler_RST) begin
    if (!Sampler_RST) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Sampler_RX_IN};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Ratio is clamped to at least 8 and forced even so mid-bit sampling is centred.
  always_comb begin
    p_eff = {Sampler_Prescale[PRESCALE_WIDTH-1:1], 1'b0};
    if (Sampler_Prescale < P_MIN) begin
      p_eff = P_MIN;
    end
  end

  assign mid      = p_lat >> 1;
  assign mid_m1   = mid - ONE;
  assign mid_p1   = mid + ONE;
  assign cnt_last = p_lat - ONE;
  assign at_last  = (edge_cnt == cnt_last);
  assign vote     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

  // Sample_Valid is a single-cycle strobe with no back-pressure: the consumer
  // must take SampledData in the cycle Sample_Valid is high.
  always_ff @(posedge Sampler_CLK or negedge Sampler_RST) begin
    if (!Sampler_RST) begin
      p_lat        <= P_MIN;
      edge_cnt     <= '0;
      s0           <= 1'b1;
      s1           <= 1'b1;
      sampled_data <= 1'b1;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!Sampler_EN) begin
        p_lat    <= p_eff;
        edge_cnt <= '0;
      end else begin
        edge_cnt <= at_last ? '0 : edge_cnt + ONE;
        if (edge_cnt == mid_m1) begin
          s0 <= rx_s;
        end
        if (edge_cnt == mid) begin
          s1 <= rx_s;
        end
        if (edge_cnt == mid_p1) begin
          sampled_data <= vote;
          sample_valid <= 1'b1;
        end
      end
    end
  end

  assign Sampler_SampledData  = sampled_data;
  assign Sampler_Sample_Valid = sample_valid;
  assign Sampler_Edge_Cnt     = edge_cnt;
  assign Sampler_Bit_Done     = Sampler_EN & at_last;

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Directed bench for uart_rx_data_sampler: each task drives one scenario and
// compares outputs against hand-derived values.
module tb_uart_rx_data_sampler;

  logic       clk;
  logic       rst_n;
  logic       rx_in;
  logic       en;
  logic [5:0] prescale;
  logic       data;
  logic       valid;
  logic [5:0] cnt;
  logic       done;

  int checks = 0;
  int errors = 0;

  uart_rx_data_sampler #(.PRESCALE_WIDTH(6), .SYNC_STAGES(2)) dut (
    .Sampler_CLK         (clk),
    .Sampler_RST         (rst_n),
    .Sampler_RX_IN       (rx_in),
    .Sampler_EN          (en),
    .Sampler_Prescale    (prescale),
    .Sampler_SampledData (data),
    .Sampler_Sample_Valid(valid),
    .Sampler_Edge_Cnt    (cnt),
    .Sampler_Bit_Done    (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    rx_in    = 1'b1;
    prescale = 6'd8;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are read 2-3 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; rx_in = 1'b1; prescale = 6'd8;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({cnt, valid, done, data} !== {6'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values got cnt=%0d v=%0b bd=%0b sd=%0b exp cnt=0 v=0 bd=0 sd=1",
               cnt, valid, done, data);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({cnt, valid, data} !== {6'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_release got cnt=%0d v=%0b sd=%0b exp cnt=0 v=0 sd=1", cnt, valid, data);
    end
  endtask

  task automatic test_steady_zero();
    logic [8:0] got, exp;
    en = 1'b0; prescale = 6'd8; rx_in = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      #1;
      got = {cnt, valid, done, data};
      exp = {6'(k % 8), (k % 8) == 6, (k % 8) == 7, k < 6};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL steady_zero k=%0d got cnt=%0d v=%0b bd=%0b sd=%0b exp cnt=%0d v=%0b bd=%0b sd=%0b",
                 k, got[8:3], got[2], got[1], got[0], exp[8:3], exp[2], exp[1], exp[0]);
      end
      tick();
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_glitch();
    logic [15:0] pat;
    pat = 16'hF90A;
    en = 1'b0; prescale = 6'd8; rx_in = 1'b1;
    repeat (3) tick();
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rx_in = pat[k];
      #1;
      if (k == 6 || k == 10 || k == 14) begin
        checks++;
        if ({valid, data} !== {k != 10, k != 14}) begin
          errors++;
          $display("FAIL glitch_vote k=%0d got v=%0b sd=%0b exp v=%0b sd=%0b",
                   k, valid, data, k != 10, k != 14);
        end
      end
      tick();
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_frame();
    logic [9:0] fr;
    logic [7:0] shreg;
    logic [7:0] got, exp;
    fr = {1'b1, 8'h5A, 1'b0};
    shreg = 8'h00;
    en = 1'b0; prescale = 6'd16; rx_in = 1'b1;
    repeat (3) tick();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 16; j++) begin
        if (j == 0) rx_in = fr[i];
        #1;
        got = {cnt, valid, done};
        exp = {6'(j), j == 10, j == 15};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL frame_timing bit=%0d j=%0d got cnt=%0d v=%0b bd=%0b exp cnt=%0d v=%0b bd=%0b",
                   i, j, got[7:2], got[1], got[0], exp[7:2], exp[1], exp[0]);
        end
        if (j == 10) begin
          checks++;
          if (data !== fr[i]) begin
            errors++;
            $display("FAIL frame_bit bit=%0d got %0b exp %0b", i, data, fr[i]);
          end
          if (i >= 1 && i <= 8) shreg = {data, shreg[7:1]};
        end
        tick();
      end
    end
    checks++;
    if (shreg !== 8'h5A) begin
      errors++;
      $display("FAIL frame_byte got 0x%02h exp 0x5A", shreg);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_prescale();
    int p_in[4];
    int p_ef[4];
    int e;
    p_in = '{8, 5, 9, 17};
    p_ef = '{8, 8, 8, 16};
    en = 1'b0; prescale = 6'd16; rx_in = 1'b1;
    tick();
    en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k == 1) prescale = 6'd8;
      #1;
      checks++;
      if ({cnt, valid} !== {6'(k % 16), (k % 16) == 10}) begin
        errors++;
        $display("FAIL prescale_frozen k=%0d got cnt=%0d v=%0b exp cnt=%0d v=%0b",
                 k, cnt, valid, k % 16, (k % 16) == 10);
      end
      tick();
    end
    for (int t = 0; t < 4; t++) begin
      en = 1'b0;
      prescale = 6'(p_in[t]);
      tick();
      en = 1'b1;
      e = p_ef[t];
      for (int k = 0; k < 2 * e; k++) begin
        #1;
        checks++;
        if ({cnt, valid, done} !== {6'(k % e), (k % e) == (e / 2 + 2), (k % e) == (e - 1)}) begin
          errors++;
          $display("FAIL prescale_eff P=%0d k=%0d got cnt=%0d v=%0b bd=%0b exp cnt=%0d v=%0b bd=%0b",
                   p_in[t], k, cnt, valid, done, k % e, (k % e) == (e / 2 + 2), (k % e) == (e - 1));
        end
        tick();
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_en_drop();
    en = 1'b0; prescale = 6'd8; rx_in = 1'b1;
    repeat (3) tick();
    en = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k == 8) rx_in = 1'b0;
      if (k == 12) en = 1'b0;
      #1;
      if (k == 6 || k == 12) begin
        checks++;
        if ({valid, done, data} !== {k == 6, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL en_drop_pre k=%0d got v=%0b bd=%0b sd=%0b exp v=%0b bd=0 sd=1",
                   k, valid, done, data, k == 6);
        end
      end
      tick();
    end
    for (int m = 0; m < 4; m++) begin
      #1;
      checks++;
      if ({cnt, valid, data} !== {6'd0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL en_drop_hold m=%0d got cnt=%0d v=%0b sd=%0b exp cnt=0 v=0 sd=1",
                 m, cnt, valid, data);
      end
      tick();
    end
    en = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    en = 1'b0;
    #1;
    checks++;
    if ({valid, done, data} !== {1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL en_drop_valid_keep got v=%0b bd=%0b sd=%0b exp v=1 bd=0 sd=0", valid, done, data);
    end
    tick();
    #1;
    checks++;
    if ({cnt, valid, data} !== {6'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL en_drop_valid_end got cnt=%0d v=%0b sd=%0b exp cnt=0 v=0 sd=0", cnt, valid, data);
    end
    tick();
  endtask

  task automatic test_async_reset();
    en = 1'b0; prescale = 6'd8; rx_in = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    for (int k = 0; k < 13; k++) tick();
    #1;
    checks++;
    if ({cnt, data} !== {6'd5, 1'b0}) begin
      errors++;
      $display("FAIL areset_pre got cnt=%0d sd=%0b exp cnt=5 sd=0", cnt, data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cnt, valid, done, data} !== {6'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL areset_immediate got cnt=%0d v=%0b bd=%0b sd=%0b exp cnt=0 v=0 bd=0 sd=1",
               cnt, valid, done, data);
    end
    tick();
    #1;
    checks++;
    if ({cnt, valid, data} !== {6'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL areset_held got cnt=%0d v=%0b sd=%0b exp cnt=0 v=0 sd=1", cnt, valid, data);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if ({cnt, valid, data} !== {6'(k), k == 6, k < 6}) begin
        errors++;
        $display("FAIL areset_restart k=%0d got cnt=%0d v=%0b sd=%0b exp cnt=%0d v=%0b sd=%0b",
                 k, cnt, valid, data, k, k == 6, k < 6);
      end
      tick();
    end
    en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_steady_zero();
    test_glitch();
    test_frame();
    test_prescale();
    test_en_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
